mem_resp_stage: RTL and testbench

- Parametrised memory-response stage for the in-order pipeline; sits between EXE (which issues data-SRAM requests) and WB.
- Holds up to DEPTH in-flight instructions in program order and matches each data_sram_data_ok pulse to the oldest waiting load/store.
- Aligns and sign/zero-extends load data, and passes a generic sideband payload through to WB.
- Cancelled requests are tracked after a flush so that their late responses are discarded.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_load_align.sv | 21 ++
 rtl/mem_resp_stage.sv | 118 +++++++++++
 tb/tb_mem_resp_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared size codes, queue entry control record and clog2 helper for the memory response stage.
package mem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef struct packed {
    logic  valid;
    logic  pending;
    logic  got;
    logic  load;
    size_e size;
    logic  uns;
    logic  ex;
  } ent_ctl_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed lane of a load response and sign/zero-extends it.
module mem_load_align import mem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_size,
  input  logic              i_uns,
  input  logic [OFF_W-1:0]  i_off,
  output logic [DATA_W-1:0] o_result
);
  logic [OFF_W-1:0]  w_al;
  logic [DATA_W-1:0] w_sh, w_mask;
  logic              w_neg;
  // lane = off >> size, so the byte offset of the lane is off with its low size bits cleared
  assign w_al     = i_off & ~((OFF_W'(1) << i_size) - OFF_W'(1));
  assign w_sh     = i_rdata >> {w_al, 3'b000};
  assign w_mask   = ~({DATA_W{1'b1}} << (7'd8 << i_size));
  assign w_neg    = !i_uns && |(w_sh & (w_mask ^ (w_mask >> 1)));
  assign o_result = w_neg ? (w_sh | ~w_mask) : (w_sh & w_mask);
endmodule

// File: rtl/mem_resp_stage.sv
// mem_resp_stage: in-order queue of in-flight memory instructions; matches data_ok to the oldest
// waiting access, drops responses of flushed requests, and hands completed results to WB.
module mem_resp_stage import mem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int SIDE_W = 160,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           exec_flush,
  input  logic                           in_valid,
  output logic                           in_allowin,
  input  logic                           in_mem_req,
  input  logic                           in_is_load,
  input  logic [1:0]                     in_size,
  input  logic                           in_unsigned,
  input  logic [clog2(DATA_W/8)-1:0]     in_addr_lo,
  input  logic                           in_ex,
  input  logic [DATA_W-1:0]              in_alu_result,
  input  logic [SIDE_W-1:0]              in_side,
  input  logic [DATA_W-1:0]              data_sram_rdata,
  input  logic                           data_sram_data_ok,
  output logic                           out_valid,
  input  logic                           wb_allowin,
  output logic [DATA_W-1:0]              out_result,
  output logic [SIDE_W-1:0]              out_side,
  output logic                           out_ex,
  output logic                           stage_valid
);
  localparam int OFF_W = clog2(DATA_W/8);
  localparam int CNT_W = clog2(DEPTH+1);
  localparam int PTR_W = clog2(DEPTH);
  ent_ctl_t          r_ctl   [DEPTH];
  logic [OFF_W-1:0]  r_off   [DEPTH];
  logic [DATA_W-1:0] r_alu   [DEPTH];
  logic [DATA_W-1:0] r_rdata [DEPTH];
  logic [SIDE_W-1:0] r_side  [DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail, w_tgt;
  logic [CNT_W-1:0]  r_count, r_discard, w_outst, w_dnext;
  logic [CNT_W:0]    w_dsum;
  logic              w_found, w_drop, w_hit, w_byp, w_pop, w_push;
  logic [DATA_W-1:0] w_rd, w_ld;
  ent_ctl_t          w_h;
  // walk from the head so the first waiting access found is the oldest
  always_comb begin
    w_found = 1'b0;
    w_tgt   = r_head;
    w_outst = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ctl[r_head + PTR_W'(i)].valid && r_ctl[r_head + PTR_W'(i)].pending && !r_ctl[r_head + PTR_W'(i)].got) begin
        if (!w_found) w_tgt = r_head + PTR_W'(i);
        w_found = 1'b1;
        w_outst = w_outst + CNT_W'(1);
      end
    end
  end
  assign w_drop      = data_sram_data_ok && (r_discard != '0);
  assign w_hit       = data_sram_data_ok && !w_drop && w_found;
  assign w_byp       = w_hit && (w_tgt == r_head);
  assign w_h         = r_ctl[r_head];
  assign out_valid   = w_h.valid && (!w_h.pending || w_h.got || w_byp);
  assign w_rd        = w_byp ? data_sram_rdata : r_rdata[r_head];
  assign out_result  = (w_h.load && !w_h.ex) ? w_ld : r_alu[r_head];
  assign out_side    = r_side[r_head];
  assign out_ex      = w_h.ex;
  assign stage_valid = r_count != '0;
  assign w_pop       = out_valid && wb_allowin;
  assign in_allowin  = (r_count < CNT_W'(DEPTH)) || w_pop;
  assign w_push      = in_valid && in_allowin && !exec_flush;
  // requests cancelled by a flush still answer later; a response matched this cycle is not one of them
  assign w_dsum  = {1'b0, r_discard} + {1'b0, w_outst} - (CNT_W+1)'(w_drop) - (CNT_W+1)'(w_hit);
  assign w_dnext = !exec_flush ? r_discard - CNT_W'(w_drop) :
                   (w_dsum > (CNT_W+1)'(DEPTH)) ? CNT_W'(DEPTH) : w_dsum[CNT_W-1:0];
  mem_load_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .i_rdata (w_rd),
    .i_size  (w_h.size),
    .i_uns   (w_h.uns),
    .i_off   (r_off[r_head]),
    .o_result(w_ld)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_discard <= '0;
      for (int i = 0; i < DEPTH; i++) r_ctl[i] <= '0;
    end else begin
      r_discard <= w_dnext;
      if (exec_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        for (int i = 0; i < DEPTH; i++) r_ctl[i].valid <= 1'b0;
      end else begin
        if (w_hit) r_ctl[w_tgt].got <= 1'b1;
        if (w_pop) begin
          r_ctl[r_head].valid <= 1'b0;
          r_head              <= r_head + PTR_W'(1);
        end
        if (w_push) begin
          r_ctl[r_tail] <= '{valid: 1'b1, pending: in_mem_req && !in_ex, got: 1'b0, load: in_is_load,
                             size: size_e'(in_size), uns: in_unsigned, ex: in_ex};
          r_tail        <= r_tail + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_hit) r_rdata[w_tgt] <= data_sram_rdata;
    if (w_push) begin
      r_off[r_tail]  <= in_addr_lo;
      r_alu[r_tail]  <= in_alu_result;
      r_side[r_tail] <= in_side;
    end
  end
endmodule

// File: tb/tb_mem_resp_stage.sv
// tb_mem_resp_stage: directed vectors and hand-written sequences for the memory response stage.
module tb_mem_resp_stage;
  logic         clk = 1'b0, reset = 1'b1;
  logic         exec_flush = 0, in_valid = 0, in_mem_req = 0, in_is_load = 0, in_unsigned = 0, in_ex = 0;
  logic [1:0]   in_size = 0, in_addr_lo = 0;
  logic [31:0]  in_alu_result = 0, data_sram_rdata = 0, out_result;
  logic [159:0] in_side = 0, out_side;
  logic         data_sram_data_ok = 0, wb_allowin = 1, in_allowin, out_valid, out_ex, stage_valid;
  logic         g_valid = 0, g_ok = 0, g_allowin, g_out_valid, g_out_ex, g_stage_valid;
  logic [1:0]   g_size = 0;
  logic [2:0]   g_off = 0;
  logic [63:0]  g_rdata = 0, g_result;
  logic [159:0] g_side;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_resp_stage dut (
    .clk(clk), .reset(reset), .exec_flush(exec_flush), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_mem_req(in_mem_req), .in_is_load(in_is_load), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr_lo(in_addr_lo), .in_ex(in_ex), .in_alu_result(in_alu_result), .in_side(in_side),
    .data_sram_rdata(data_sram_rdata), .data_sram_data_ok(data_sram_data_ok), .out_valid(out_valid),
    .wb_allowin(wb_allowin), .out_result(out_result), .out_side(out_side), .out_ex(out_ex),
    .stage_valid(stage_valid)
  );
  mem_resp_stage #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset), .exec_flush(1'b0), .in_valid(g_valid), .in_allowin(g_allowin),
    .in_mem_req(1'b1), .in_is_load(1'b1), .in_size(g_size), .in_unsigned(1'b0),
    .in_addr_lo(g_off), .in_ex(1'b0), .in_alu_result(64'h0), .in_side(160'h0),
    .data_sram_rdata(g_rdata), .data_sram_data_ok(g_ok), .out_valid(g_out_valid),
    .wb_allowin(1'b1), .out_result(g_result), .out_side(g_side), .out_ex(g_out_ex),
    .stage_valid(g_stage_valid)
  );
  typedef struct {
    logic        load;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic        req;
    logic        ex;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;
  vec_t v [11];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  task automatic put_ld(input logic [1:0] sz, input logic [1:0] off);
    in_valid = 1; in_mem_req = 1; in_is_load = 1; in_ex = 0; in_size = sz; in_unsigned = 0;
    in_addr_lo = off; in_alu_result = 32'h0;
  endtask
  initial begin
    v[0]  = '{1, 2'd2, 0, 2'd0, 1, 0, 32'h0,        32'h8765_4321, 32'h8765_4321};
    v[1]  = '{1, 2'd0, 0, 2'd3, 1, 0, 32'h0,        32'h8012_3456, 32'hFFFF_FF80};
    v[2]  = '{1, 2'd0, 1, 2'd3, 1, 0, 32'h0,        32'h8012_3456, 32'h0000_0080};
    v[3]  = '{1, 2'd1, 0, 2'd2, 1, 0, 32'h0,        32'hF00D_1234, 32'hFFFF_F00D};
    v[4]  = '{1, 2'd1, 1, 2'd2, 1, 0, 32'h0,        32'hF00D_1234, 32'h0000_F00D};
    v[5]  = '{1, 2'd0, 0, 2'd1, 1, 0, 32'h0,        32'h1234_5678, 32'h0000_0056};
    v[6]  = '{1, 2'd1, 0, 2'd0, 1, 0, 32'h0,        32'h0000_8001, 32'hFFFF_8001};
    v[7]  = '{0, 2'd2, 0, 2'd0, 1, 0, 32'hDEAD_BEEF, 32'h1111_1111, 32'hDEAD_BEEF};
    v[8]  = '{1, 2'd2, 0, 2'd0, 1, 1, 32'h0000_0001, 32'h0,         32'h0000_0001};
    v[9]  = '{0, 2'd2, 0, 2'd0, 0, 0, 32'h0000_0005, 32'h0,         32'h0000_0005};
    v[10] = '{1, 2'd0, 1, 2'd0, 1, 0, 32'h0,        32'h0000_00FF, 32'h0000_00FF};
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_allowin", in_allowin, 1);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1; in_is_load = v[i].load; in_size = v[i].size; in_unsigned = v[i].uns;
      in_addr_lo = v[i].off; in_mem_req = v[i].req; in_ex = v[i].ex; in_alu_result = v[i].alu;
      in_side = {5{32'hA5A5_0000 + 32'(i)}};
      #1 chk($sformatf("v%0d_allowin", i), in_allowin, 1);
      @(negedge clk) in_valid = 0;
      if (v[i].req && !v[i].ex) begin
        #1 chk($sformatf("v%0d_wait", i), out_valid, 0);
        data_sram_data_ok = 1; data_sram_rdata = v[i].rdata;
      end
      #1;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_result", i), out_result, v[i].exp);
      chk($sformatf("v%0d_ex", i), out_ex, v[i].ex);
      chk($sformatf("v%0d_side_lo", i), out_side[63:0], {2{32'hA5A5_0000 + 32'(i)}});
      chk($sformatf("v%0d_side_hi", i), out_side[159:96], {2{32'hA5A5_0000 + 32'(i)}});
      @(negedge clk) data_sram_data_ok = 0;
      #1 chk($sformatf("v%0d_drained", i), stage_valid, 0);
    end
    // lw with two cycles of memory latency
    @(negedge clk) put_ld(2'd2, 2'd0);
    @(negedge clk) in_valid = 0;
    #1 chk("lat_wait1", out_valid, 0);
    @(negedge clk) data_sram_data_ok = 1; data_sram_rdata = 32'h8765_4321;
    #1 chk("lat_valid", out_valid, 1);
    chk("lat_result", out_result, 32'h8765_4321);
    @(negedge clk) data_sram_data_ok = 0;
    // back-to-back loads with WB stalled
    wb_allowin = 0;
    @(negedge clk) put_ld(2'd2, 2'd0);
    @(negedge clk) put_ld(2'd2, 2'd0);
    #1 chk("b2b_allow2", in_allowin, 1);
    @(negedge clk) data_sram_data_ok = 1; data_sram_rdata = 32'h11;
    #1 chk("b2b_full", in_allowin, 0);
    chk("b2b_byp_valid", out_valid, 1);
    chk("b2b_byp_result", out_result, 32'h11);
    @(negedge clk) in_valid = 0; data_sram_rdata = 32'h22;
    #1 chk("b2b_head_held", out_result, 32'h11);
    @(negedge clk) data_sram_data_ok = 0; wb_allowin = 1;
    #1 chk("b2b_first_valid", out_valid, 1);
    chk("b2b_first", out_result, 32'h11);
    @(negedge clk) #1 chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second", out_result, 32'h22);
    @(negedge clk) #1 chk("b2b_empty", stage_valid, 0);
    // flush with two outstanding loads: the next two responses are dropped
    @(negedge clk) put_ld(2'd2, 2'd0);
    @(negedge clk) put_ld(2'd2, 2'd0);
    @(negedge clk) in_valid = 0; exec_flush = 1;
    @(negedge clk) exec_flush = 0;
    #1 chk("fl_empty", stage_valid, 0);
    put_ld(2'd2, 2'd0); data_sram_data_ok = 1; data_sram_rdata = 32'hAA;
    #1 chk("fl_drop1", out_valid, 0);
    @(negedge clk) in_valid = 0; data_sram_rdata = 32'hBB;
    #1 chk("fl_drop2", out_valid, 0);
    chk("fl_held", stage_valid, 1);
    @(negedge clk) data_sram_rdata = 32'hCC;
    #1 chk("fl_new_valid", out_valid, 1);
    chk("fl_new_result", out_result, 32'hCC);
    @(negedge clk) data_sram_data_ok = 0;
    #1 chk("fl_drained", stage_valid, 0);
    // flush in the same cycle as the oldest load's response: only one response is dropped
    @(negedge clk) put_ld(2'd2, 2'd0);
    @(negedge clk) put_ld(2'd2, 2'd0);
    @(negedge clk) in_valid = 0; exec_flush = 1; data_sram_data_ok = 1; data_sram_rdata = 32'h99;
    #1 chk("fc_byp_result", out_result, 32'h99);
    @(negedge clk) exec_flush = 0; put_ld(2'd2, 2'd0); data_sram_rdata = 32'h77;
    #1 chk("fc_drop", out_valid, 0);
    @(negedge clk) in_valid = 0; data_sram_rdata = 32'h66;
    #1 chk("fc_new_valid", out_valid, 1);
    chk("fc_new_result", out_result, 32'h66);
    @(negedge clk) data_sram_data_ok = 0;
    #1 chk("fc_drained", stage_valid, 0);
    // 64-bit data path: ld and a sign-extended lw from the upper word
    @(negedge clk) g_valid = 1; g_size = 2'd3; g_off = 3'd0;
    @(negedge clk) g_valid = 0; g_ok = 1; g_rdata = 64'hFEDC_BA98_7654_3210;
    #1 chk("ld64_valid", g_out_valid, 1);
    chk("ld64_result", g_result, 64'hFEDC_BA98_7654_3210);
    @(negedge clk) g_ok = 0; g_valid = 1; g_size = 2'd2; g_off = 3'd4;
    @(negedge clk) g_valid = 0; g_ok = 1; g_rdata = 64'h8000_0000_1234_5678;
    #1 chk("lw64_valid", g_out_valid, 1);
    chk("lw64_result", g_result, 64'hFFFF_FFFF_8000_0000);
    @(negedge clk) g_ok = 0;
    #1 chk("g_drained", g_stage_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
